// File: rtl/proc_run_ctrl.sv
// -----------------------------------------------------------------------------
// proc_run_ctrl
//
// Run controller for the single-cycle CPU. On a start request it loads the
// CPU start PC and holds the CPU in reset for RESET_CYCLES clocks. It then lets
// the program run until the CPU PC reaches the latched end address. At that
// point it captures MemtoRegOut and compares it with the latched expected
// value. A watchdog stops runs that never reach the end address.
//
// Parameters
//   RESET_CYCLES  clocks cpu_resetl is held low after start (1..15)
//   WD_LIMIT      RUN clocks allowed before timeout (>= 1)
//
// Ports
//   CLK              clock, all state changes on the rising edge
//   resetl           asynchronous active-low reset
//   start            one-cycle run request (accepted in IDLE/DONE/TIMEOUT)
//   start_addr       start PC for the run
//   end_addr         run ends when CPU PC >= this value (unsigned)
//   expected         expected MemtoRegOut at the end of the run
//   cpu_resetl       drives the CPU resetl input
//   cpu_startpc      drives the CPU startpc input
//   cpu_currentpc    CPU currentpc
//   cpu_memtoregout  CPU MemtoRegOut
//   busy             high in RESET or RUN
//   done             high in DONE or TIMEOUT
//   pass             high in DONE when the result matches
//   timeout          high in TIMEOUT
//   result           captured MemtoRegOut
//   cycle_count      RUN clocks elapsed before termination
// -----------------------------------------------------------------------------
module proc_run_ctrl #(
  parameter int unsigned RESET_CYCLES = 2,
  parameter logic [15:0] WD_LIMIT     = 16'h00FF
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic        start,
  input  logic [63:0] start_addr,
  input  logic [63:0] end_addr,
  input  logic [63:0] expected,
  output logic        cpu_resetl,
  output logic [63:0] cpu_startpc,
  input  logic [63:0] cpu_currentpc,
  input  logic [63:0] cpu_memtoregout,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [63:0] result,
  output logic [15:0] cycle_count
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RESET   = 3'd1;
  localparam logic [2:0] ST_RUN     = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;

  localparam logic [3:0]  RST_LAST = 4'(RESET_CYCLES - 1);
  localparam logic [15:0] WD_LAST  = WD_LIMIT - 16'd1;

  logic [2:0]  state_q,       state_d;
  logic [3:0]  rst_cnt_q,     rst_cnt_d;
  logic        cpu_resetl_q,  cpu_resetl_d;
  logic [63:0] cpu_startpc_q, cpu_startpc_d;
  logic [63:0] end_q,         end_d;
  logic [63:0] exp_q,         exp_d;
  logic        busy_q,        busy_d;
  logic        done_q,        done_d;
  logic        pass_q,        pass_d;
  logic        timeout_q,     timeout_d;
  logic [63:0] result_q,      result_d;
  logic [15:0] cycle_count_q, cycle_count_d;

  logic        idle_like;
  logic        end_hit;

  // A new run is accepted from any terminal or idle state.
  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE) ||
                     (state_q == ST_TIMEOUT);
  assign end_hit   = (cpu_currentpc >= end_q);

  always_comb begin
    // NOTE: every _d signal gets a hold default first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    cpu_resetl_d  = cpu_resetl_q;
    cpu_startpc_d = cpu_startpc_q;
    end_d         = end_q;
    exp_d         = exp_q;
    busy_d        = busy_q;
    done_d        = done_q;
    pass_d        = pass_q;
    timeout_d     = timeout_q;
    result_d      = result_q;
    cycle_count_d = cycle_count_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_TIMEOUT: begin
        // The CPU free-runs whenever no run is being set up.
        cpu_resetl_d = 1'b1;
        if (start) begin
          cpu_startpc_d = start_addr;
          end_d         = end_addr;
          exp_d         = expected;
          result_d      = '0;
          cycle_count_d = '0;
          pass_d        = 1'b0;
          done_d        = 1'b0;
          timeout_d     = 1'b0;
          cpu_resetl_d  = 1'b0;
          busy_d        = 1'b1;
          rst_cnt_d     = '0;
          state_d       = ST_RESET;
        end
      end

      ST_RESET: begin
        rst_cnt_d = rst_cnt_q + 4'd1;
        if (rst_cnt_q == RST_LAST) begin
          cpu_resetl_d = 1'b1;
          state_d      = ST_RUN;
        end
      end

      ST_RUN: begin
        // End detection has priority over watchdog expiry on the same edge.
        if (end_hit) begin
          result_d = cpu_memtoregout;
          pass_d   = (cpu_memtoregout == exp_q);
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = ST_DONE;
        end else if (cycle_count_q == WD_LAST) begin
          timeout_d     = 1'b1;
          done_d        = 1'b1;
          busy_d        = 1'b0;
          cycle_count_d = WD_LIMIT;
          state_d       = ST_TIMEOUT;
        end else begin
          cycle_count_d = cycle_count_q + 16'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q       <= ST_IDLE;
      rst_cnt_q     <= '0;
      cpu_resetl_q  <= 1'b0;
      cpu_startpc_q <= '0;
      end_q         <= '0;
      exp_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
      result_q      <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      cpu_resetl_q  <= cpu_resetl_d;
      cpu_startpc_q <= cpu_startpc_d;
      end_q         <= end_d;
      exp_q         <= exp_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      timeout_q     <= timeout_d;
      result_q      <= result_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign cpu_resetl  = cpu_resetl_q;
  assign cpu_startpc = cpu_startpc_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign result      = result_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: doc/proc_run_ctrl.md
Name: proc_run_ctrl

Overview:
- Run controller wrapped around the single-cycle CPU (`singlecycle`); it drives the CPU's reset and start PC.
- On `start`, it holds the CPU in reset for a fixed number of cycles, then releases it.
- It watches `currentpc` until the program-end address is reached, then captures `MemtoRegOut` and compares it against an expected value.
- A watchdog flags runaway programs. Hardware equivalent of the bench's run/check loop, usable for on-board self-test.

Parameters:
RESET_CYCLES, 2, cycles `cpu_resetl` is held low after `start` (1..15)
WD_LIMIT, 16'h00FF, RUN cycles allowed before timeout (>=1)

Ports:
CLK  in  1  clock; all state updates on posedge
resetl  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to begin a run
start_addr  in  64  PC loaded into the CPU for the run
end_addr  in  64  run ends when CPU PC >= this value (unsigned)
expected  in  64  expected MemtoRegOut at end of run
cpu_resetl  out  1  to CPU `resetl`
cpu_startpc  out  64  to CPU `startpc`
cpu_currentpc  in  64  from CPU `currentpc`
cpu_memtoregout  in  64  from CPU `MemtoRegOut`
busy  out  1  high in RESET or RUN
done  out  1  high in DONE (pass or fail) or TIMEOUT
pass  out  1  high only in DONE with a matching result
timeout  out  1  high only in TIMEOUT
result  out  64  captured MemtoRegOut
cycle_count  out  16  RUN cycles elapsed before termination

Behaviour:
- Reset (`resetl`=0, asynchronous):
  - state=IDLE, `cpu_resetl`=0, `cpu_startpc`=0.
  - `busy`=`done`=`pass`=`timeout`=0, `result`=0, `cycle_count`=0.
  - Internal latched end/expected registers are cleared.
- All outputs are registered. `cpu_resetl` goes to 1 on the first posedge after reset release (IDLE drives 1).
- States: IDLE, RESET, RUN, DONE, TIMEOUT.
- IDLE/DONE/TIMEOUT, `start`=1 at a posedge:
  - Latch `start_addr` into `cpu_startpc`, and latch `end_addr` and `expected`.
  - Clear `result`, `cycle_count`, `pass`, `done`, `timeout`.
  - Set `cpu_resetl`=0, `busy`=1, reset counter=0; go to RESET.
- `start` while in RESET or RUN is ignored; latched values are unchanged.
- RESET:
  - Reset counter increments each posedge.
  - When counter == RESET_CYCLES-1: set `cpu_resetl`=1 and go to RUN. `cpu_resetl` is therefore low for exactly RESET_CYCLES posedges.
- RUN, evaluated at each posedge using current inputs:
  - If `cpu_currentpc` >= latched end (64-bit unsigned):
    - `result` <= `cpu_memtoregout`.
    - `pass` <= (`cpu_memtoregout` == latched expected).
    - `done`=1, `busy`=0; go to DONE.
    - `cycle_count` is not incremented on this edge.
  - Else if `cycle_count` == WD_LIMIT-1:
    - `timeout`=1, `done`=1, `busy`=0.
    - `cycle_count` <= WD_LIMIT; go to TIMEOUT.
  - Else `cycle_count` <= `cycle_count`+1.
- If end-address detection and watchdog expiry occur on the same edge, end detection wins (DONE, not TIMEOUT).
- In DONE/TIMEOUT, `cpu_resetl` stays 1 (CPU free-runs) and `result`/`pass`/`cycle_count` hold until the next `start`.
- `cpu_startpc` holds its latched value outside a `start` edge.
- `cycle_count` never wraps; the maximum value is WD_LIMIT.
- `resetl` asserted mid-run: everything returns to reset values immediately. `cpu_resetl`=0 holds the CPU in reset, and no result is reported.
- `end_addr` <= `start_addr`: the run terminates on the first RUN edge with `cycle_count`=0.

Test Plan:
1. Reset, then `start` with `start_addr`=0, `end_addr`=0x34, `expected`=0x123456789abcdef0; CPU model PC +4 per cycle from 0, MemtoRegOut=0x123456789abcdef0 at PC 0x34 -> `cpu_resetl` low exactly 2 cycles, `done`=1, `pass`=1, `result`=0x123456789abcdef0, `cycle_count`=13.
2. Same as 1 but `expected`=0xF -> `done`=1, `pass`=0, `timeout`=0, `result`=0x123456789abcdef0.
3. CPU PC stuck at 0x10, `end_addr`=0x34, WD_LIMIT=0xFF -> after 255 RUN cycles `timeout`=1, `done`=1, `pass`=0, `cycle_count`=0xFF.
4. PC reaches `end_addr` on the same edge `cycle_count`==WD_LIMIT-1 (WD_LIMIT=4, PC steps 0,4,8,0xC, `end_addr`=0xC) -> DONE with `timeout`=0, `cycle_count`=3.
5. `start` pulsed again mid-RUN with `start_addr`=0x100 -> ignored, `cpu_startpc` stays 0. Then `resetl` pulsed low mid-RUN -> `busy`=0, `cpu_resetl`=0, `result`=0 asynchronously.
6. `start_addr`=0x40, `end_addr`=0x20 -> `cpu_startpc`=0x40, DONE on the first RUN edge, `cycle_count`=0. Back-to-back `start` from DONE restarts and clears `pass`/`done` the next cycle.
